// File: rtl/sc_dmem_pkg.sv
// Shared types and constants for the dual-port data-memory arbiter.
package sc_dmem_pkg;

  localparam int DMEM_AW_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Grant owner encoding, also used for the last-grant register.
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/sc_rr_arb2.sv
// Two-input round-robin picker: on a tie the port not granted last wins.
module sc_rr_arb2
  import sc_dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant; a lone requester always wins.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last == OWN_B)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

endmodule

// File: rtl/sc_dmem_arbiter.sv
// Arbitrates a CPU port (A) and an IO/debug port (B) onto one single-port
// data RAM with one-cycle registered read latency.
//
// state | meaning
// IDLE  | waiting for a request; arbitrate and latch the winner
// ISSUE | one cycle: ack (and err) visible, RAM strobed if in range
// WAIT  | read data returning from RAM; captured at the end of this cycle
module sc_dmem_arbiter
  import sc_dmem_pkg::*;
#(
  parameter int DMEM_AW = DMEM_AW_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               a_req,
  input  logic               a_we,
  input  logic [31:0]        a_addr,
  input  logic [31:0]        a_wdata,
  output logic               a_ack,
  output logic               a_err,
  output logic               a_rvalid,
  output logic [31:0]        a_rdata,
  input  logic               b_req,
  input  logic               b_we,
  input  logic [31:0]        b_addr,
  input  logic [31:0]        b_wdata,
  output logic               b_ack,
  output logic               b_err,
  output logic               b_rvalid,
  output logic [31:0]        b_rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [DMEM_AW-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata,
  output logic               busy
);

  state_t               state, state_nxt;
  logic [1:0]           gnt;
  logic                 last, own;
  logic                 r_we, r_oor;
  logic [DMEM_AW-1:0]   r_waddr;
  logic [31:0]          r_wdata;

  logic                 accept, pick;
  logic [31:0]          sel_addr;
  logic                 sel_oor;
  logic                 rsp_fire;
  logic [31:0]          rsp_data;
  logic                 addr_lsb_unused;

  sc_rr_arb2 u_arb (
    .req  ({b_req, a_req}),
    .last (last),
    .gnt  (gnt)
  );

  // Winner selection; the byte-offset bits never reach the RAM.
  always_comb begin
    accept   = (state == IDLE) && (gnt != 2'b00);
    pick     = gnt[1] ? OWN_B : OWN_A;
    sel_addr = gnt[1] ? b_addr : a_addr;
    sel_oor  = |sel_addr[31:DMEM_AW+2];
  end

  assign addr_lsb_unused = ^sel_addr[1:0];

  // Next state, RAM strobes and read-response strobe.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    rsp_fire  = 1'b0;
    rsp_data  = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_en = !r_oor;
        mem_we = !r_oor && r_we;
        // Out-of-range reads still complete, returning zero.
        rsp_fire  = r_oor && !r_we;
        state_nxt = (!r_oor && !r_we) ? WAIT : IDLE;
      end
      WAIT: begin
        rsp_fire  = 1'b1;
        rsp_data  = mem_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr  = r_waddr;
  assign mem_wdata = r_wdata;
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Latch the accepted request and remember who won for round-robin.
  always_ff @(posedge clock) begin
    if (reset) begin
      last    <= OWN_B;
      own     <= OWN_A;
      r_we    <= 1'b0;
      r_oor   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (accept) begin
      last    <= pick;
      own     <= pick;
      r_we    <= gnt[1] ? b_we : a_we;
      r_oor   <= sel_oor;
      r_waddr <= sel_addr[DMEM_AW+1:2];
      r_wdata <= gnt[1] ? b_wdata : a_wdata;
    end
  end

  // Registered ack/err/rvalid pulses and per-port read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_ack    <= accept && (pick == OWN_A);
      b_ack    <= accept && (pick == OWN_B);
      a_err    <= accept && (pick == OWN_A) && sel_oor;
      b_err    <= accept && (pick == OWN_B) && sel_oor;
      a_rvalid <= rsp_fire && (own == OWN_A);
      b_rvalid <= rsp_fire && (own == OWN_B);
      if (rsp_fire && own == OWN_A) a_rdata <= rsp_data;
      if (rsp_fire && own == OWN_B) b_rdata <= rsp_data;
    end
  end

endmodule

// File: tb/tb_sc_dmem_arbiter.sv
// Directed bench for sc_dmem_arbiter with a behavioural one-cycle RAM.
module tb_sc_dmem_arbiter;

  localparam int AW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [31:0]   a_addr, a_wdata, b_addr, b_wdata;
  logic          a_ack, a_err, a_rvalid, b_ack, b_err, b_rvalid;
  logic [31:0]   a_rdata, b_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;

  logic [31:0]   ram [0:63];
  logic          fill;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  sc_dmem_arbiter #(.DMEM_AW(AW)) dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // RAM: writes commit at the strobe edge, reads return one cycle later.
  always @(posedge clock) begin
    if (fill) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h1000_0000 + i;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Responses must never go to both ports at once.
  always @(negedge clock) begin
    if (!reset && !fill)
      chk("port_excl", {29'd0, a_ack & b_ack, a_err & b_err, a_rvalid & b_rvalid}, 32'd0);
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drive one request and wait (bounded) for its ack; k is the cycle index
  // relative to the sampling edge (edge 0 -> cycle 1 holds the ack).
  task automatic req_ack(input bit pb, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int t0, output int k,
                         output bit err);
    if (pb) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else    begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
    t0  = cyc + 1;
    k   = -1;
    err = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (pb ? b_ack : a_ack) begin
        k   = cyc - t0 + 1;
        err = pb ? b_err : a_err;
        break;
      end
    end
    if (pb) b_req = 1'b0;
    else    a_req = 1'b0;
  endtask

  task automatic wait_rv(input bit pb, input int t0, output int k, output logic [31:0] d);
    k = -1;
    d = 32'hxxxx_xxxx;
    for (int n = 0; n < 10; n++) begin
      if (pb ? b_rvalid : a_rvalid) begin
        k = cyc - t0 + 1;
        d = pb ? b_rdata : a_rdata;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int          t0, k, nacks, nrv, rvcnt, bchg;
    bit          e;
    logic [31:0] d, bref;
    int          order [0:5];
    int          ackc  [0:2];
    int          rvc   [0:2];
    logic [31:0] rvd   [0:2];

    a_we = 0; b_we = 0; a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
    a_req = 0; b_req = 0;
    fill  = 1'b1;
    reset = 1'b1;
    tick();
    fill = 1'b0;
    tick();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ack", {30'd0, a_ack, b_ack}, 0);
    chk("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_mem_en", {30'd0, mem_en, mem_we}, 0);
    reset = 1'b0;

    // A write 0x10 then read it back.
    req_ack(0, 1, 32'h10, 32'hDEADBEEF, t0, k, e);
    chk("wr_ack_cycle", k, 1);
    chk("wr_err", {31'd0, e}, 0);
    chk("wr_mem_en", {31'd0, mem_en}, 1);
    chk("wr_mem_we", {31'd0, mem_we}, 1);
    chk("wr_mem_addr", {26'd0, mem_addr}, 4);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("wr_busy_after", {31'd0, busy}, 0);
    chk("wr_ram", ram[4], 32'hDEADBEEF);
    req_ack(0, 0, 32'h10, 0, t0, k, e);
    chk("rd_ack_cycle", k, 1);
    chk("rd_mem_we", {30'd0, mem_en, mem_we}, 32'd2);
    chk("rd_mem_addr", {26'd0, mem_addr}, 4);
    tick();
    chk("rd_wait_mem_en", {30'd0, mem_en, mem_we}, 0);
    chk("rd_wait_busy", {31'd0, busy}, 1);
    wait_rv(0, t0, k, d);
    chk("rd_rvalid_cycle", k, 3);
    chk("rd_data", d, 32'hDEADBEEF);

    // Simultaneous reads after reset: A first, then strict alternation.
    do_reset();
    a_req = 1; a_we = 0; a_addr = 32'h0;
    b_req = 1; b_we = 0; b_addr = 32'h4;
    nacks = 0;
    for (int n = 0; n < 40 && nacks < 4; n++) begin
      tick();
      if (a_ack) begin order[nacks] = 0; nacks++; end
      if (b_ack) begin order[nacks] = 1; nacks++; end
    end
    a_req = 0; b_req = 0;
    for (int n = 0; n < 4; n++) tick();
    chk("rr_nacks", nacks, 4);
    chk("rr_order0", order[0], 0);
    chk("rr_order1", order[1], 1);
    chk("rr_order2", order[2], 0);
    chk("rr_order3", order[3], 1);
    chk("rr_a_rdata", a_rdata, 32'h1000_0000);
    chk("rr_b_rdata", b_rdata, 32'h1000_0001);

    // Out-of-range B write is dropped; out-of-range A read returns zero.
    req_ack(1, 1, 32'h100, 32'h1234_5678, t0, k, e);
    chk("oor_wr_ack_cycle", k, 1);
    chk("oor_wr_err", {31'd0, e}, 1);
    chk("oor_wr_mem", {30'd0, mem_en, mem_we}, 0);
    tick();
    chk("oor_wr_ram", ram[0], 32'h1000_0000);
    req_ack(0, 0, 32'h100, 0, t0, k, e);
    chk("oor_rd_err", {31'd0, e}, 1);
    chk("oor_rd_mem", {30'd0, mem_en, mem_we}, 0);
    wait_rv(0, t0, k, d);
    chk("oor_rd_rvalid_cycle", k, 2);
    chk("oor_rd_data", d, 0);

    // Reset during WAIT aborts the read.
    req_ack(0, 0, 32'h10, 0, t0, k, e);
    tick();
    chk("abort_in_wait", {31'd0, busy}, 1);
    reset = 1'b1;
    tick();
    chk("abort_busy", {31'd0, busy}, 0);
    reset = 1'b0;
    rvcnt = 0;
    for (int n = 0; n < 5; n++) begin
      if (a_rvalid || a_ack) rvcnt++;
      tick();
    end
    chk("abort_no_resp", rvcnt, 0);
    chk("abort_rdata", a_rdata, 0);
    req_ack(0, 0, 32'h8, 0, t0, k, e);
    chk("post_abort_ack", k, 1);
    wait_rv(0, t0, k, d);
    chk("post_abort_rv", k, 3);
    chk("post_abort_data", d, 32'h1000_0002);

    // Back-to-back A reads; B's read data must not move.
    req_ack(1, 0, 32'h14, 0, t0, k, e);
    wait_rv(1, t0, k, bref);
    chk("b_ref", bref, 32'h1000_0005);
    tick();
    a_req = 1; a_we = 0; a_addr = 32'h0;
    nacks = 0; nrv = 0; bchg = 0;
    for (int n = 0; n < 40 && nrv < 3; n++) begin
      tick();
      if (b_rdata !== bref) bchg++;
      if (a_ack && nacks < 3) begin
        ackc[nacks] = cyc;
        nacks++;
        if (nacks < 3) a_addr = nacks * 4;
        else           a_req = 1'b0;
      end
      if (a_rvalid && nrv < 3) begin
        rvc[nrv] = cyc;
        rvd[nrv] = a_rdata;
        nrv++;
      end
    end
    a_req = 0;
    chk("b2b_nrv", nrv, 3);
    chk("b2b_d0", rvd[0], 32'h1000_0000);
    chk("b2b_d1", rvd[1], 32'h1000_0001);
    chk("b2b_d2", rvd[2], 32'h1000_0002);
    chk("b2b_gap1", ackc[1] - rvc[0], 1);
    chk("b2b_gap2", ackc[2] - rvc[1], 1);
    chk("b2b_b_stable", bchg, 0);

    // Byte-offset bits are ignored.
    tick();
    req_ack(0, 0, 32'h13, 0, t0, k, e);
    chk("lsb_mem_addr", {26'd0, mem_addr}, 4);
    wait_rv(0, t0, k, d);
    chk("lsb_data", d, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
